wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//   Shares the single Wishbone master port to SRAM between three clients: CPU (0), VGA (1), UART (2).
//   Uses the VGA_state hint so that display fetches are never delayed during active video.
//   Drives current_client, which tells the IO controller which client owns the bus.
//   Sits between the client request ports and the SRAM Wishbone slave.
// PARAMETERS
//   TIMEOUT_CYCLES  16  max cycles in ISSUE waiting for ack_i before abort; 0 = timeout disabled
// PORTS
//   clk             in   1   system clock
//   nrst            in   1   asynchronous, active-low reset
//   vga_state       in   2   0 = inactive, 1 = about to be active, 2 = active (3 treated as 0)
//   cpu_req/uart_req in  1   request, held with fields stable until own ack/err pulse
//   cpu_we/uart_we  in   1   1 = write
//   cpu_adr/uart_adr in  32  word address
//   cpu_wdat/uart_wdat in 32 write data
//   cpu_sel/uart_sel in  4   byte select
//   vga_req         in   1   VGA read request (VGA never writes)
//   vga_adr         in   32  VGA word address
//   vga_sel         in   4   VGA byte select
//   cpu_ack/vga_ack/uart_ack  out 1  1-cycle completion pulse to owning client
//   cpu_err/vga_err/uart_err  out 1  1-cycle timeout-abort pulse to owning client
//   rdata           out  32  read data latched from dat_i, valid in the ack/err cycle, held until next latch
//   current_client  out  2   0 CPU, 1 VGA, 2 UART, 3 none (registered)
//   cyc_o, stb_o, we_o  out  1   Wishbone master controls
//   adr_o           out  32  Wishbone address
//   dat_o           out  32  Wishbone write data
//   sel_o           out  4   Wishbone byte select
//   dat_i           in   32  Wishbone read data
//   ack_i           in   1   Wishbone acknowledge
// BEHAVIOUR
//   Reset (async): FSM = IDLE; all outputs 0; current_client = 3; rr_ptr = CPU; timeout counter = 0.
//   FSM states: IDLE -> ISSUE -> DONE -> IDLE.
//   IDLE: arbitrate among requests sampled this cycle. A grant registers the client's fields,
//     sets current_client and moves to ISSUE. No request: stay IDLE, current_client = 3.
//   Priority:
//     vga_state == 2: only VGA may be granted; CPU/UART stall.
//     vga_state == 1: VGA may be granted; CPU/UART new grants blocked so the bus drains.
//     Otherwise: VGA first, then round-robin CPU/UART via rr_ptr.
//     rr_ptr toggles to the other client after each CPU/UART grant.
//   ISSUE: cyc_o = stb_o = 1; adr_o/dat_o/sel_o/we_o from the latched fields (we_o = 0 for VGA).
//     On ack_i: latch dat_i into rdata (reads only), go to DONE (ok).
//     Timeout: counter increments each ISSUE cycle. When it reaches TIMEOUT_CYCLES without ack_i,
//     drop cyc_o/stb_o, set rdata = 0, go to DONE (err).
//     ack_i in the same cycle the timeout is reached: ack wins.
//   DONE: cyc_o = stb_o = 0; pulse owner's ack (or err) for exactly 1 cycle; current_client held;
//     next state IDLE. Minimum 3 cycles per transaction if ack_i arrives in the first ISSUE cycle.
//   No preemption: an in-flight transaction always completes or times out, even if vga_state
//     changes or the owner drops req. The ack/err pulse is still issued.
//   req still high in IDLE after its ack = new request.
//   ack_i outside ISSUE is ignored.
//   Reset mid-transaction: cyc_o/stb_o drop immediately (async); no ack/err pulse is emitted.
// TESTING
//   Reset: nrst=0 during ISSUE -> cyc_o=0, current_client=3, all acks 0 immediately.
//   Round-robin: cpu_req & uart_req held, vga_state=0, ack_i 1 cycle after stb -> grants alternate CPU, UART, CPU.
//   VGA priority: vga_state=2 with all three requesting -> only VGA granted; CPU/UART ack stay 0 until vga_state=0.
//   Drain: vga_state=1, cpu_req rises while IDLE -> no CPU grant; vga_req with adr 0x3E84 -> adr_o=0x3E84, we_o=0.
//   Timeout: TIMEOUT_CYCLES=4, ack_i never -> stb_o high 4 cycles, then uart_err pulse, rdata=0, back to IDLE.
//   Read data: CPU read, dat_i=0xDEADBEEF with ack_i -> next cycle cpu_ack=1, rdata=0xDEADBEEF.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Three-client Wishbone arbiter (CPU=0, VGA=1, UART=2) in front of the SRAM slave.
// VGA is favoured using the vga_state hint; CPU/UART share the remaining slots round-robin.
module wb_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  vga_state,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdat,
    input  logic [3:0]  cpu_sel,

    input  logic        vga_req,
    input  logic [31:0] vga_adr,
    input  logic [3:0]  vga_sel,

    input  logic        uart_req,
    input  logic        uart_we,
    input  logic [31:0] uart_adr,
    input  logic [31:0] uart_wdat,
    input  logic [3:0]  uart_sel,

    output logic        cpu_ack,
    output logic        vga_ack,
    output logic        uart_ack,
    output logic        cpu_err,
    output logic        vga_err,
    output logic        uart_err,
    output logic [31:0] rdata,
    output logic [1:0]  current_client,

    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CL_CPU  = 2'd0,
        CL_VGA  = 2'd1,
        CL_UART = 2'd2,
        CL_NONE = 2'd3
    } client_t;

    state_t        state_q, state_d;
    client_t       cur_q, cur_d;
    logic          rr_q, rr_d;       // 0: CPU preferred next, 1: UART preferred next
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          cu_allowed;
    logic          timeout_hit;

    // CPU/UART may only start while the display is neither active nor about to be.
    assign cu_allowed  = (vga_state == 2'd0) || (vga_state == 2'd3);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cur_q   <= CL_NONE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                cur_d = CL_NONE;
                err_d = 1'b0;
                cnt_d = '0;
                if (vga_req) begin
                    cur_d   = CL_VGA;
                    we_d    = 1'b0;
                    adr_d   = vga_adr;
                    dat_d   = '0;
                    sel_d   = vga_sel;
                    state_d = ISSUE;
                end else if (cu_allowed && cpu_req && (!rr_q || !uart_req)) begin
                    cur_d   = CL_CPU;
                    we_d    = cpu_we;
                    adr_d   = cpu_adr;
                    dat_d   = cpu_wdat;
                    sel_d   = cpu_sel;
                    rr_d    = 1'b1;
                    state_d = ISSUE;
                end else if (cu_allowed && uart_req) begin
                    cur_d   = CL_UART;
                    we_d    = uart_we;
                    adr_d   = uart_adr;
                    dat_d   = uart_wdat;
                    sel_d   = uart_sel;
                    rr_d    = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CW'(1);
                if (ack_i) begin
                    if (!we_q) begin
                        rdata_d = dat_i;
                    end
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_ack  = 1'b0;
        vga_ack  = 1'b0;
        uart_ack = 1'b0;
        cpu_err  = 1'b0;
        vga_err  = 1'b0;
        uart_err = 1'b0;
        if (state_q == DONE) begin
            cpu_ack  = !err_q && (cur_q == CL_CPU);
            vga_ack  = !err_q && (cur_q == CL_VGA);
            uart_ack = !err_q && (cur_q == CL_UART);
            cpu_err  =  err_q && (cur_q == CL_CPU);
            vga_err  =  err_q && (cur_q == CL_VGA);
            uart_err =  err_q && (cur_q == CL_UART);
        end
    end

    assign cyc_o          = (state_q == ISSUE);
    assign stb_o          = (state_q == ISSUE);
    assign we_o           = we_q;
    assign adr_o          = adr_q;
    assign dat_o          = dat_q;
    assign sel_o          = sel_q;
    assign rdata          = rdata_q;
    assign current_client = cur_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: directed stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever an ack/err pulse appears.
module tb_wb_bus_arbiter;

    logic        clk;
    logic        nrst;
    logic [1:0]  vga_state;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_adr, cpu_wdat;
    logic [3:0]  cpu_sel;
    logic        vga_req;
    logic [31:0] vga_adr;
    logic [3:0]  vga_sel;
    logic        uart_req, uart_we;
    logic [31:0] uart_adr, uart_wdat;
    logic [3:0]  uart_sel;
    logic        cpu_ack, vga_ack, uart_ack;
    logic        cpu_err, vga_err, uart_err;
    logic [31:0] rdata;
    logic [1:0]  current_client;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;

    wb_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .nrst(nrst), .vga_state(vga_state),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdat(cpu_wdat), .cpu_sel(cpu_sel),
        .vga_req(vga_req), .vga_adr(vga_adr), .vga_sel(vga_sel),
        .uart_req(uart_req), .uart_we(uart_we), .uart_adr(uart_adr), .uart_wdat(uart_wdat), .uart_sel(uart_sel),
        .cpu_ack(cpu_ack), .vga_ack(vga_ack), .uart_ack(uart_ack),
        .cpu_err(cpu_err), .vga_err(vga_err), .uart_err(uart_err),
        .rdata(rdata), .current_client(current_client),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
        .dat_i(dat_i), .ack_i(ack_i)
    );

    typedef struct {
        logic [1:0]  client;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] adr;
        logic        we;
        int unsigned stb;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;

    logic        slave_en = 1'b0;
    logic        spurious = 1'b0;
    int          ack_delay = 0;
    logic [31:0] slave_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wishbone slave: acks after ack_delay wait cycles in ISSUE, or never when disabled.
    initial begin
        int wcnt;
        wcnt  = 0;
        ack_i = 1'b0;
        dat_i = '0;
        forever begin
            @(negedge clk);
            if (spurious) begin
                ack_i = 1'b1;
                dat_i = 32'hFFFF_FFFF;
            end else if (slave_en && stb_o) begin
                if (wcnt == ack_delay) begin
                    ack_i = 1'b1;
                    dat_i = slave_data;
                    wcnt  = 0;
                end else begin
                    ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                ack_i = 1'b0;
                wcnt  = 0;
            end
        end
    end

    // Monitor: tracks strobe length/address and scores every completion pulse.
    initial begin
        int unsigned stb_cnt;
        logic [31:0] mon_adr;
        logic        mon_we;
        logic [2:0]  acks, errs, bits;
        logic [1:0]  cl;
        exp_t        e;
        stb_cnt = 0;
        mon_adr = '0;
        mon_we  = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                stb_cnt = 0;
            end else if (stb_o) begin
                stb_cnt++;
                mon_adr = adr_o;
                mon_we  = we_o;
            end
            acks = {uart_ack, vga_ack, cpu_ack};
            errs = {uart_err, vga_err, cpu_err};
            bits = acks | errs;
            if (bits != 3'b000) begin
                vectors++;
                cl = bits[0] ? 2'd0 : (bits[1] ? 2'd1 : 2'd2);
                if ($countones({acks, errs}) != 1) begin
                    miscompares++;
                    $display("FAIL onehot_pulse: got ack=%b err=%b, need exactly one pulse", acks, errs);
                end else if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_completion: got client %0d err %0b, none expected", cl, |errs);
                end else begin
                    e = sb.pop_front();
                    if (cl !== e.client || (|errs) !== e.err || rdata !== e.rdata ||
                        mon_adr !== e.adr || mon_we !== e.we || stb_cnt != e.stb) begin
                        miscompares++;
                        $display("FAIL completion: got client=%0d err=%0b rdata=%h adr=%h we=%0b stb=%0d; need client=%0d err=%0b rdata=%h adr=%h we=%0b stb=%0d",
                                 cl, |errs, rdata, mon_adr, mon_we, stb_cnt,
                                 e.client, e.err, e.rdata, e.adr, e.we, e.stb);
                    end
                end
                stb_cnt = 0;
                done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic er, input logic [31:0] rd,
                        input logic [31:0] ad, input logic w, input int unsigned s);
        exp_t e;
        e.client = c; e.err = er; e.rdata = rd; e.adr = ad; e.we = w; e.stb = s;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 40 && done_cnt < target; i++) tick(1);
        check(name, done_cnt, target);
    endtask

    task automatic wait_stb(input string name);
        for (int i = 0; i < 40 && !stb_o; i++) tick(1);
        check(name, {31'b0, stb_o}, 32'd1);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        cpu_req = 1'b0; vga_req = 1'b0; uart_req = 1'b0;
        tick(2);
        nrst = 1'b1;
        tick(1);
    endtask

    initial begin
        int base;
        nrst = 1'b0; vga_state = 2'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdat = '0; cpu_sel = 4'hF;
        vga_req = 1'b0; vga_adr = '0; vga_sel = 4'hF;
        uart_req = 1'b0; uart_we = 1'b0; uart_adr = '0; uart_wdat = '0; uart_sel = 4'hF;
        tick(2);
        check("reset_cyc", {31'b0, cyc_o}, 32'd0);
        check("reset_client", {30'b0, current_client}, 32'd3);
        check("reset_pulses", {26'b0, cpu_ack, vga_ack, uart_ack, cpu_err, vga_err, uart_err}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        nrst = 1'b1;
        tick(1);

        // CPU read, ack in first ISSUE cycle
        slave_en = 1'b1; ack_delay = 0; slave_data = 32'hDEAD_BEEF;
        push(2'd0, 1'b0, 32'hDEAD_BEEF, 32'h100, 1'b0, 1);
        cpu_we = 1'b0; cpu_adr = 32'h100; cpu_req = 1'b1;
        base = done_cnt;
        wait_done(base + 1, "read_done");
        cpu_req = 1'b0;
        tick(2);
        check("rdata_hold", rdata, 32'hDEAD_BEEF);

        // Round-robin CPU, UART, CPU with both held
        do_reset();
        ack_delay = 1; slave_data = 32'h5555_AAAA;
        cpu_we = 1'b1; cpu_adr = 32'h10; cpu_wdat = 32'h1111_1111;
        uart_we = 1'b0; uart_adr = 32'h20;
        push(2'd0, 1'b0, 32'h0,         32'h10, 1'b1, 2);
        push(2'd2, 1'b0, 32'h5555_AAAA, 32'h20, 1'b0, 2);
        push(2'd0, 1'b0, 32'h5555_AAAA, 32'h10, 1'b1, 2);
        base = done_cnt;
        cpu_req = 1'b1; uart_req = 1'b1;
        wait_stb("rr_first_stb");
        check("rr_first_owner", {30'b0, current_client}, 32'd0);
        check("rr_cpu_dat_o", dat_o, 32'h1111_1111);
        wait_done(base + 3, "rr_done");
        cpu_req = 1'b0; uart_req = 1'b0;
        tick(2);

        // VGA active: only VGA served, CPU/UART stall until vga_state returns to 0
        do_reset();
        ack_delay = 0; slave_data = 32'hCAFE_F00D; vga_state = 2'd2;
        vga_adr = 32'h3000;
        cpu_we = 1'b1; cpu_adr = 32'h40; cpu_wdat = 32'h22;
        uart_we = 1'b1; uart_adr = 32'h24; uart_wdat = 32'h33;
        push(2'd1, 1'b0, 32'hCAFE_F00D, 32'h3000, 1'b0, 1);
        push(2'd1, 1'b0, 32'hCAFE_F00D, 32'h3000, 1'b0, 1);
        base = done_cnt;
        cpu_req = 1'b1; vga_req = 1'b1; uart_req = 1'b1;
        wait_done(base + 2, "vga_done");
        vga_req = 1'b0;
        tick(6);
        check("vga_active_stall_stb", {31'b0, stb_o}, 32'd0);
        check("vga_active_stall_client", {30'b0, current_client}, 32'd3);
        push(2'd0, 1'b0, 32'hCAFE_F00D, 32'h40, 1'b1, 1);
        push(2'd2, 1'b0, 32'hCAFE_F00D, 32'h24, 1'b1, 1);
        vga_state = 2'd0;
        wait_done(base + 4, "vga_release_done");
        cpu_req = 1'b0; uart_req = 1'b0;
        tick(2);

        // Drain: vga_state=1 blocks new CPU grants, VGA still served
        do_reset();
        vga_state = 2'd1; slave_data = 32'h0BAD_F00D;
        cpu_we = 1'b0; cpu_adr = 32'h50; cpu_req = 1'b1;
        tick(5);
        check("drain_cpu_blocked", {31'b0, stb_o}, 32'd0);
        check("drain_client_none", {30'b0, current_client}, 32'd3);
        push(2'd1, 1'b0, 32'h0BAD_F00D, 32'h3E84, 1'b0, 1);
        vga_adr = 32'h3E84; vga_sel = 4'h3;
        base = done_cnt;
        vga_req = 1'b1;
        wait_stb("drain_vga_stb");
        check("drain_adr_o", adr_o, 32'h3E84);
        check("drain_we_o", {31'b0, we_o}, 32'd0);
        check("drain_sel_o", {28'b0, sel_o}, 32'h3);
        check("drain_owner", {30'b0, current_client}, 32'd1);
        wait_done(base + 1, "drain_vga_done");
        vga_req = 1'b0;
        tick(4);
        check("drain_cpu_still_blocked", {31'b0, stb_o}, 32'd0);
        push(2'd0, 1'b0, 32'h0BAD_F00D, 32'h50, 1'b0, 1);
        vga_state = 2'd0;
        wait_done(base + 2, "drain_cpu_done");
        cpu_req = 1'b0;
        tick(2);

        // Timeout: UART read, slave silent -> 4 strobe cycles then uart_err, rdata cleared
        slave_en = 1'b0;
        uart_we = 1'b0; uart_adr = 32'h80;
        push(2'd2, 1'b1, 32'h0, 32'h80, 1'b0, 4);
        base = done_cnt;
        uart_req = 1'b1;
        wait_done(base + 1, "timeout_done");
        uart_req = 1'b0;
        tick(2);
        check("timeout_back_idle", {30'b0, current_client}, 32'd3);
        check("timeout_rdata_zero", rdata, 32'd0);

        // Ack arriving in the very cycle the timeout is reached wins
        slave_en = 1'b1; ack_delay = 3; slave_data = 32'h600D_CAFE;
        cpu_we = 1'b0; cpu_adr = 32'h90;
        push(2'd0, 1'b0, 32'h600D_CAFE, 32'h90, 1'b0, 4);
        base = done_cnt;
        cpu_req = 1'b1;
        wait_done(base + 1, "ack_wins_done");
        cpu_req = 1'b0;
        tick(2);

        // ack_i while IDLE must be ignored
        spurious = 1'b1;
        tick(4);
        spurious = 1'b0;
        check("spurious_ack_stb", {31'b0, stb_o}, 32'd0);
        check("spurious_ack_rdata", rdata, 32'h600D_CAFE);

        // Reset mid-transaction: bus released at once, no pulse
        slave_en = 1'b0;
        cpu_adr = 32'hA0; cpu_req = 1'b1;
        wait_stb("rst_mid_stb");
        #3;
        nrst = 1'b0;
        #1;
        check("rst_mid_cyc", {31'b0, cyc_o}, 32'd0);
        check("rst_mid_stb_low", {31'b0, stb_o}, 32'd0);
        check("rst_mid_client", {30'b0, current_client}, 32'd3);
        check("rst_mid_pulses", {26'b0, cpu_ack, vga_ack, uart_ack, cpu_err, vga_err, uart_err}, 32'd0);
        cpu_req = 1'b0;
        tick(2);
        nrst = 1'b1;
        tick(3);
        check("rst_mid_idle", {31'b0, stb_o}, 32'd0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
